// File: rtl/meteo_disp_seq_if.sv
// Bus between the per-channel segment encoders, the mode/select controls and the
// board display pins of the meteo display sequencer.
interface meteo_disp_seq_if #(
    parameter int NCH  = 3,
    parameter int NDIG = 6,
    parameter int SEGW = 7,
    parameter int IW   = 2
);
    logic [NCH*NDIG*SEGW-1:0] Seg_i;
    logic [NCH-1:0]           Upd_i;
    logic [1:0]               Mode_i;
    logic [NCH-1:0]           Sel_i;
    logic [NDIG*SEGW-1:0]     Dec_o;
    logic [IW-1:0]            Chan_o;
    logic                     Valid_o;

    modport master (
        output Seg_i, Upd_i, Mode_i, Sel_i,
        input  Dec_o, Chan_o, Valid_o
    );

    modport slave (
        input  Seg_i, Upd_i, Mode_i, Sel_i,
        output Dec_o, Chan_o, Valid_o
    );
endinterface

// File: rtl/meteo_disp_seq.sv
// 7-segment display sequencer: shadows NCH channels of pre-encoded digits and drives one
// of them to the display in blank, manual, timed auto-rotation or freeze mode.
module meteo_disp_seq #(
    parameter int             NCH   = 3,
    parameter int             NDIG  = 6,
    parameter int             SEGW  = 7,
    parameter logic [SEGW-1:0] BLANK = 7'h7F,
    parameter int             DWELL = 100000000,
    parameter int             CW    = 27,
    parameter int             IW    = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    meteo_disp_seq_if.slave   bus
);

    localparam int DW = NDIG * SEGW;
    localparam logic [DW-1:0] BLANK_ALL = {NDIG{BLANK}};

    typedef enum logic [1:0] {
        MODE_BLANK  = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    logic [DW-1:0]  shadow_r [NCH];
    logic [NCH-1:0] valid_r;
    logic [DW-1:0]  dec_r;
    logic [IW-1:0]  chan_r;
    logic           vld_r;
    logic [CW-1:0]  cnt_r;
    mode_e          mode_prev_r;

    mode_e          mode_s;
    logic [IW-1:0]  chan_nxt_s;
    logic [CW-1:0]  cnt_eff_s;
    logic [CW-1:0]  cnt_nxt_s;
    logic           show_s;
    logic [DW-1:0]  dec_nxt_s;
    logic           vld_nxt_s;

    // Index of the lowest set bit of a one-hot (or multi-hot) select vector.
    function automatic logic [IW-1:0] lowest_set(input logic [NCH-1:0] sel);
        logic [IW-1:0] res;
        logic          hit;
        res = '0;
        hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            res = (sel[i] && !hit) ? IW'(i) : res;
            hit = hit | sel[i];
        end
        return res;
    endfunction

    // Next valid channel after cur (wrapping); cur itself is kept if no other is valid.
    function automatic logic [IW-1:0] next_chan(input logic [IW-1:0] cur,
                                                input logic [NCH-1:0] vld);
        logic [IW-1:0] res;
        logic          hit;
        int            idx;
        res = cur;
        hit = 1'b0;
        for (int i = 1; i < NCH; i++) begin
            idx = int'(cur) + i;
            idx = (idx >= NCH) ? idx - NCH : idx;
            res = (vld[idx] && !hit) ? IW'(idx) : res;
            hit = hit | vld[idx];
        end
        return res;
    endfunction

    assign mode_s = mode_e'(bus.Mode_i);

    // Mode decode: next channel, dwell counter and the display word to load.
    always_comb begin
        chan_nxt_s = chan_r;
        cnt_nxt_s  = '0;
        show_s     = 1'b0;
        // A fresh entry into auto (e.g. out of freeze) restarts the dwell from zero.
        cnt_eff_s  = (mode_prev_r == MODE_AUTO) ? cnt_r : '0;
        case (mode_s)
            MODE_BLANK: begin
                show_s = 1'b0;
            end
            MODE_MANUAL: begin
                if (|bus.Sel_i) begin
                    chan_nxt_s = lowest_set(bus.Sel_i);
                    show_s     = 1'b1;
                end else begin
                    show_s     = 1'b0;
                end
            end
            MODE_AUTO: begin
                show_s = 1'b1;
                if (cnt_eff_s == CW'(DWELL - 1)) begin
                    cnt_nxt_s  = '0;
                    chan_nxt_s = next_chan(chan_r, valid_r);
                end else begin
                    cnt_nxt_s  = cnt_eff_s + CW'(1);
                end
            end
            MODE_FREEZE: begin
                cnt_nxt_s = cnt_r;
            end
            default: begin
                show_s = 1'b0;
            end
        endcase
        vld_nxt_s = show_s && valid_r[chan_nxt_s];
        dec_nxt_s = vld_nxt_s ? shadow_r[chan_nxt_s] : BLANK_ALL;
    end

    // Shadow capture plus the registered display, channel and dwell state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int c = 0; c < NCH; c++) begin
                shadow_r[c] <= BLANK_ALL;
            end
            valid_r     <= '0;
            dec_r       <= BLANK_ALL;
            chan_r      <= '0;
            vld_r       <= 1'b0;
            cnt_r       <= '0;
            mode_prev_r <= MODE_BLANK;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.Upd_i[c]) begin
                    shadow_r[c] <= bus.Seg_i[c*DW +: DW];
                    valid_r[c]  <= 1'b1;
                end
            end
            if (mode_s != MODE_FREEZE) begin
                dec_r  <= dec_nxt_s;
                vld_r  <= vld_nxt_s;
                chan_r <= chan_nxt_s;
            end
            cnt_r       <= cnt_nxt_s;
            mode_prev_r <= mode_s;
        end
    end

    assign bus.Dec_o   = dec_r;
    assign bus.Chan_o  = chan_r;
    assign bus.Valid_o = vld_r;

endmodule

// File: tb/tb_meteo_disp_seq.sv
// Directed self-checking bench for meteo_disp_seq with a short dwell (DWELL=4).
module tb_meteo_disp_seq;

    localparam int NCH  = 3;
    localparam int NDIG = 6;
    localparam int SEGW = 7;
    localparam int IW   = 2;
    localparam int DW   = NDIG * SEGW;
    localparam logic [DW-1:0] BLANK_ALL = 42'h3FFFFFFFFFF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    meteo_disp_seq_if #(.NCH(NCH), .NDIG(NDIG), .SEGW(SEGW), .IW(IW)) bus ();

    meteo_disp_seq #(
        .NCH(NCH), .NDIG(NDIG), .SEGW(SEGW), .BLANK(7'h7F),
        .DWELL(4), .CW(3), .IW(IW)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [SEGW-1:0] d);
        return {NDIG{d}};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [IW-1:0] seq3 [4];
        logic [IW-1:0] seq4 [4];
        seq3[0] = 2'd0; seq3[1] = 2'd1; seq3[2] = 2'd2; seq3[3] = 2'd0;
        seq4[0] = 2'd0; seq4[1] = 2'd2; seq4[2] = 2'd0; seq4[3] = 2'd2;

        // Reset for two cycles with captures requested (must be ignored).
        rst = 1'b1;
        bus.Mode_i = 2'b00;
        bus.Sel_i  = 3'b000;
        bus.Upd_i  = 3'b111;
        bus.Seg_i  = {rep(7'h24), rep(7'h79), rep(7'h40)};
        step(2);
        chk("rst_dec",   64'(bus.Dec_o),   64'(BLANK_ALL));
        chk("rst_chan",  64'(bus.Chan_o),  64'd0);
        chk("rst_valid", 64'(bus.Valid_o), 64'd0);

        rst = 1'b0;
        bus.Upd_i  = 3'b000;
        bus.Mode_i = 2'b01;
        bus.Sel_i  = 3'b001;
        step(1);
        chk("rst_upd_ignored_dec",   64'(bus.Dec_o),   64'(BLANK_ALL));
        chk("rst_upd_ignored_valid", 64'(bus.Valid_o), 64'd0);

        // Capture all channels, manual select of ch1: two-edge latency.
        bus.Upd_i = 3'b111;
        bus.Sel_i = 3'b010;
        step(1);
        bus.Upd_i = 3'b000;
        chk("man_lat1_valid", 64'(bus.Valid_o), 64'd0);
        chk("man_lat1_chan",  64'(bus.Chan_o),  64'd1);
        step(1);
        chk("man_ch1_dec",   64'(bus.Dec_o),   64'(rep(7'h79)));
        chk("man_ch1_valid", 64'(bus.Valid_o), 64'd1);

        bus.Sel_i = 3'b110;
        step(1);
        chk("man_multi_chan", 64'(bus.Chan_o), 64'd1);
        chk("man_multi_dec",  64'(bus.Dec_o),  64'(rep(7'h79)));

        bus.Sel_i = 3'b100;
        step(1);
        chk("man_ch2_chan", 64'(bus.Chan_o), 64'd2);
        chk("man_ch2_dec",  64'(bus.Dec_o),  64'(rep(7'h24)));

        bus.Sel_i = 3'b000;
        step(1);
        chk("man_none_dec",   64'(bus.Dec_o),   64'(BLANK_ALL));
        chk("man_none_valid", 64'(bus.Valid_o), 64'd0);
        chk("man_none_chan",  64'(bus.Chan_o),  64'd2);

        // Auto rotation over three valid channels, 4 cycles per channel.
        bus.Sel_i = 3'b001;
        step(1);
        chk("man_ch0_dec", 64'(bus.Dec_o), 64'(rep(7'h40)));
        bus.Mode_i = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step(3);
            chk("auto3_hold", 64'(bus.Chan_o), 64'(seq3[k]));
            step(1);
            chk("auto3_next", 64'(bus.Chan_o), 64'(seq3[k+1]));
        end

        // Reset mid-dwell while rotating.
        step(2);
        rst = 1'b1;
        step(1);
        chk("midrst_dec",   64'(bus.Dec_o),   64'(BLANK_ALL));
        chk("midrst_chan",  64'(bus.Chan_o),  64'd0);
        chk("midrst_valid", 64'(bus.Valid_o), 64'd0);
        rst = 1'b0;

        // No valid channel in auto: blank, channel held.
        bus.Mode_i = 2'b01;
        bus.Sel_i  = 3'b100;
        step(1);
        chk("inv_sel_chan",  64'(bus.Chan_o),  64'd2);
        chk("inv_sel_valid", 64'(bus.Valid_o), 64'd0);
        bus.Mode_i = 2'b10;
        step(5);
        chk("auto_none_chan", 64'(bus.Chan_o), 64'd2);
        chk("auto_none_dec",  64'(bus.Dec_o),  64'(BLANK_ALL));

        // Only ch0 and ch2 valid: rotation skips ch1.
        bus.Mode_i = 2'b00;
        bus.Upd_i  = 3'b101;
        step(1);
        bus.Upd_i  = 3'b000;
        chk("blank_dec", 64'(bus.Dec_o), 64'(BLANK_ALL));
        bus.Mode_i = 2'b01;
        bus.Sel_i  = 3'b001;
        step(1);
        chk("skip_start_dec", 64'(bus.Dec_o), 64'(rep(7'h40)));
        bus.Mode_i = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step(3);
            chk("auto2_hold", 64'(bus.Chan_o), 64'(seq4[k]));
            step(1);
            chk("auto2_next", 64'(bus.Chan_o), 64'(seq4[k+1]));
        end
        chk("auto2_dec", 64'(bus.Dec_o), 64'(rep(7'h24)));

        // Freeze holds the display while the shadow keeps capturing.
        bus.Mode_i = 2'b11;
        step(1);
        bus.Seg_i[2*DW +: DW] = rep(7'h30);
        bus.Upd_i = 3'b100;
        step(1);
        bus.Upd_i = 3'b000;
        step(2);
        chk("frz_dec",  64'(bus.Dec_o),  64'(rep(7'h24)));
        chk("frz_chan", 64'(bus.Chan_o), 64'd2);
        bus.Mode_i = 2'b01;
        bus.Sel_i  = 3'b100;
        step(1);
        chk("unfrz_dec",   64'(bus.Dec_o),   64'(rep(7'h30)));
        chk("unfrz_valid", 64'(bus.Valid_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
